// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// data-memory wait freezes with a timeout watchdog, plus saturating perf counters.
module hazard_controller #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t           r_state;
  logic [WC_W-1:0]  r_wait_cnt;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  logic w_mem_stall;
  logic w_load_use;
  logic w_pc_we, w_ifid_we, w_ifid_flush, w_idex_bubble, w_idex_we, w_exmem_we, w_memwb_bubble;

  assign w_mem_stall = mem_req && !mem_ready;
  assign w_load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                        (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Priority: error freeze, memory freeze, branch flush, load-use stall.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_pc_we        = 1'b1;
    w_ifid_we      = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_bubble  = 1'b0;
    w_idex_we      = 1'b1;
    w_exmem_we     = 1'b1;
    w_memwb_bubble = 1'b0;
    if (!rst_n) begin
      w_pc_we        = 1'b0;
      w_ifid_we      = 1'b0;
      w_idex_we      = 1'b0;
      w_exmem_we     = 1'b0;
      w_ifid_flush   = 1'b1;
      w_idex_bubble  = 1'b1;
      w_memwb_bubble = 1'b1;
    end else if ((r_state == ERR) || w_mem_stall) begin
      w_pc_we        = 1'b0;
      w_ifid_we      = 1'b0;
      w_idex_we      = 1'b0;
      w_exmem_we     = 1'b0;
      w_memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
    end else if (w_load_use) begin
      w_pc_we       = 1'b0;
      w_ifid_we     = 1'b0;
      w_idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_wait_cnt     <= '0;
      r_mem_timeout  <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!w_mem_stall) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WC_W'(TIMEOUT - 1)) begin
            r_state       <= ERR;
            r_mem_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ERR:     r_state <= ERR;
        default: r_state <= RUN;
      endcase
      if (!w_pc_we && (r_stall_cycles != {CNT_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_ifid_flush && (r_flush_count != {CNT_W{1'b1}}))
        r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign pc_we        = w_pc_we;
  assign ifid_we      = w_ifid_we;
  assign ifid_flush   = w_ifid_flush;
  assign idex_bubble  = w_idex_bubble;
  assign idex_we      = w_idex_we;
  assign exmem_we     = w_exmem_we;
  assign memwb_bubble = w_memwb_bubble;
  assign mem_timeout  = r_mem_timeout;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller (TIMEOUT=4, CNT_W=4): vector table,
// expected-enable queue and a saturating counter model.
module tb_hazard_controller;

  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  // {pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we, memwb_bubble}
  localparam logic [6:0] DEF = 7'b1100110;
  localparam logic [6:0] FRZ = 7'b0000001;
  localparam logic [6:0] BRF = 7'b1111110;
  localparam logic [6:0] LU  = 7'b0001110;
  localparam logic [6:0] RST = 7'b0011001;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, br, req, rdy;
    logic [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we, memwb_bubble, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  logic [6:0] exp_q[$];
  vec_t tbl[13];

  hazard_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .idex_we(idex_we), .exmem_we(exmem_we),
    .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] act();
    return {pc_we, ifid_we, ifid_flush, idex_bubble, idex_we, exmem_we, memwb_bubble};
  endfunction

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic mr, input logic br, input logic req,
                              input logic rdy, input logic [6:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.mr = mr; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one vector just after a rising edge, compare enables mid-cycle,
  // then compare counters just after the following edge.
  task automatic apply(input string name, input vec_t v);
    logic [6:0] e;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_rd = v.rd; ex_mem_read = v.mr; ex_branch_taken = v.br;
    mem_req = v.req; mem_ready = v.rdy;
    exp_q.push_back(v.exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check({name, "_en"}, {25'd0, act()}, {25'd0, e});
    @(posedge clk);
    #1;
    if (!e[6] && exp_stall != MAX) exp_stall++;
    if (e[4] && exp_flush != MAX) exp_flush++;
    check({name, "_stall_cnt"}, {28'd0, stall_cycles}, exp_stall);
    check({name, "_flush_cnt"}, {28'd0, flush_count}, exp_flush);
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #1;
    check({name, "_rst_en"}, {25'd0, act()}, {25'd0, RST});
    check({name, "_rst_stall"}, {28'd0, stall_cycles}, 0);
    check({name, "_rst_flush"}, {28'd0, flush_count}, 0);
    check({name, "_rst_timeout"}, {31'd0, mem_timeout}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
  endtask

  initial begin
    vec_t idle, stall, ready;
    idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF);
    stall = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ);
    ready = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, DEF);

    tbl[0]  = idle;
    tbl[1]  = mk(0, 5, 0, 1, 5, 1, 0, 0, 0, LU);   // load-use on rs2
    tbl[2]  = idle;
    tbl[3]  = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, DEF);  // ex_rd = x0
    tbl[4]  = mk(0, 5, 0, 0, 5, 1, 0, 0, 0, DEF);  // rs2 not used
    tbl[5]  = mk(7, 3, 1, 0, 7, 1, 0, 0, 0, LU);   // load-use on rs1
    tbl[6]  = mk(0, 5, 0, 1, 5, 1, 1, 0, 0, BRF);  // branch overrides load-use
    tbl[7]  = stall;
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ);  // branch held by freeze
    tbl[9]  = mk(0, 5, 0, 1, 5, 1, 0, 1, 0, FRZ);  // load-use held by freeze
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, BRF);  // release with pending branch
    tbl[11] = idle;
    tbl[12] = ready;

    rst_n = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0; ex_rd = '0;
    ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_en", {25'd0, act()}, {25'd0, RST});
    check("reset_stall", {28'd0, stall_cycles}, 0);
    check("reset_flush", {28'd0, flush_count}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) apply($sformatf("vec%0d", i), tbl[i]);
    check("table_timeout", {31'd0, mem_timeout}, 0);

    // Reset in the middle of a memory wait leaves no residual wait count.
    apply("mw_a", stall);
    apply("mw_b", stall);
    do_reset("mw");
    for (int i = 0; i < TO - 1; i++) apply($sformatf("near_%0d", i), stall);
    apply("near_ready", ready);
    apply("near_idle", idle);
    check("near_timeout", {31'd0, mem_timeout}, 0);

    // Watchdog: TIMEOUT stalled cycles enter ERR; freeze persists; counter saturates.
    do_reset("to");
    for (int i = 0; i < TO - 1; i++) apply($sformatf("to_%0d", i), stall);
    check("to_before", {31'd0, mem_timeout}, 0);
    apply("to_last", stall);
    check("to_after", {31'd0, mem_timeout}, 1);
    for (int i = 0; i < 16; i++)
      apply($sformatf("err_%0d", i), mk(0, 5, 0, 1, 5, 1, 1, 0, 0, FRZ));
    check("sat_stall", {28'd0, stall_cycles}, 15);
    check("err_timeout_held", {31'd0, mem_timeout}, 1);

    do_reset("err");
    apply("post_err", idle);
    check("post_err_timeout", {31'd0, mem_timeout}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
